// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle add/sub/compare, iterative shift-add multiply and restoring divide.
// Define ULA_SEQ_MULDIV_EN to build the multi-cycle mul/div datapath; otherwise mul/div complete at once with err set.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_NE  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             finish;
    logic [WIDTH-1:0] res;
    logic             res_cy;
    logic             res_err;
    logic [WIDTH:0]   add_sum;

`ifdef ULA_SEQ_MULDIV_EN
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d, p_next;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_ge;

    // p holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
        if (is_div_q) begin
            p_next = {div_rem, p_q[WIDTH-2:0], div_ge};
        end else begin
            p_next = {mul_sum, p_q[WIDTH-1:1]};
        end
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        finish  = 1'b0;
        res     = '0;
        res_cy  = 1'b0;
        res_err = 1'b0;
        add_sum = {1'b0, a} + {1'b0, b};
`ifdef ULA_SEQ_MULDIV_EN
        cnt_d    = cnt_q;
        p_d      = p_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    finish = 1'b1;
                    case (op)
                        OP_ADD: begin
                            res    = add_sum[WIDTH-1:0];
                            res_cy = add_sum[WIDTH];
                        end
                        OP_SUB: begin
                            res    = a - b;
                            res_cy = (a < b);
                        end
                        OP_EQ: res = WIDTH'(a == b);
                        OP_GT: res = WIDTH'(a > b);
                        OP_LT: res = WIDTH'(a < b);
                        OP_NE: res = WIDTH'(a != b);
                        default: begin
`ifdef ULA_SEQ_MULDIV_EN
                            if (op == OP_DIV && b == '0) begin
                                res     = '1;
                                res_err = 1'b1;
                            end else begin
                                finish   = 1'b0;
                                state_d  = CALC;
                                cnt_d    = '0;
                                is_div_d = (op == OP_DIV);
                                p_d      = {{WIDTH{1'b0}}, (op == OP_DIV) ? a : b};
                                opb_d    = (op == OP_DIV) ? b : a;
                            end
`else
                            res_err = 1'b1;
`endif
                        end
                    endcase
                end
            end
`ifdef ULA_SEQ_MULDIV_EN
            CALC: begin
                p_d   = p_next;
                cnt_d = cnt_q + 1'b1;
                // The last iteration writes the result directly so CALC lasts exactly WIDTH cycles.
                if (cnt_q == LAST_ITER) begin
                    finish = 1'b1;
                    res    = p_next[WIDTH-1:0];
                    res_cy = !is_div_q && (|p_next[2*WIDTH-1:WIDTH]);
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d = DONE;
            out_d   = res;
            carry_d = res_cy;
            zero_d  = (res == '0);
            err_d   = res_err;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ULA_SEQ_MULDIV_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
`ifdef ULA_SEQ_MULDIV_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

`ifdef ULA_SEQ_MULDIV_EN
    // NOTE: the iterative datapath is not reset; it is always loaded on acceptance before being read.
    always_ff @(posedge clk) begin
        p_q      <= p_d;
        opb_q    <= opb_d;
        is_div_q <= is_div_d;
    end
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule
